// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// wb_port_arbiter_pkg : shared widths, FSM encoding and RF write-port record
// Revision : 1.0
// ============================================================================
package wb_port_arbiter_pkg;

   localparam int WORD_LEN          = 32;
   localparam int REG_FILE_ADDR_LEN = 5;

   typedef enum logic [0:0] {
      WB_ARB_IDLE = 1'b0,
      WB_ARB_PEND = 1'b1
   } wb_arb_state_t;

   typedef struct packed {
      logic                         we;
      logic [REG_FILE_ADDR_LEN-1:0] addr;
      logic [WORD_LEN-1:0]          data;
   } rf_write_t;

   localparam rf_write_t RF_WRITE_NONE = '{we: 1'b0, addr: '0, data: '0};

   function automatic rf_write_t rf_write(input logic [REG_FILE_ADDR_LEN-1:0] addr,
                                          input logic [WORD_LEN-1:0]          data);
      rf_write_t w;
      w.we   = 1'b1;
      w.addr = addr;
      w.data = data;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// wb_port_arbiter_if : MEM/WB writeback requests in, register-file port out
// Revision : 1.0
// ============================================================================
interface wb_port_arbiter_if;
   import wb_port_arbiter_pkg::*;

   logic                         wb_en_i;
   logic                         mem_r_en_i;
   logic [REG_FILE_ADDR_LEN-1:0] dest_i;
   logic [WORD_LEN-1:0]          alu_res_i;
   logic [WORD_LEN-1:0]          mem_read_val_i;
   logic                         add_base_i;
   logic [REG_FILE_ADDR_LEN-1:0] base_addr_i;
   logic [WORD_LEN-1:0]          val1_i;

   logic                         rf_we_o;
   logic [REG_FILE_ADDR_LEN-1:0] rf_addr_o;
   logic [WORD_LEN-1:0]          rf_data_o;
   logic                         stall_o;

   // master drives the MEM/WB side, slave is the arbiter
   modport master (
      output wb_en_i, mem_r_en_i, dest_i, alu_res_i, mem_read_val_i,
             add_base_i, base_addr_i, val1_i,
      input  rf_we_o, rf_addr_o, rf_data_o, stall_o
   );

   modport slave (
      input  wb_en_i, mem_r_en_i, dest_i, alu_res_i, mem_read_val_i,
             add_base_i, base_addr_i, val1_i,
      output rf_we_o, rf_addr_o, rf_data_o, stall_o
   );

endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// wb_port_arbiter : serialises primary and base-update writes onto one RF port
// Optional: define WB_STALL_COUNT_EN to add the saturating stall_cnt_o counter
// Revision : 1.0
// ============================================================================
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   wb_port_arbiter_if.slave  wb
`ifdef WB_STALL_COUNT_EN
   ,
   output logic [31:0]       stall_cnt_o
`endif
);

   wb_arb_state_t                state;
   logic [REG_FILE_ADDR_LEN-1:0] pend_addr;
   logic [WORD_LEN-1:0]          pend_data;

   logic [WORD_LEN-1:0]          prim_data;
   logic                         dual_req;
   rf_write_t                    port;
   logic                         stall;

   assign prim_data = wb.mem_r_en_i ? wb.mem_read_val_i : wb.alu_res_i;

   // Same target for both writes collapses to the primary write alone
   assign dual_req  = wb.wb_en_i & wb.add_base_i & (wb.dest_i != wb.base_addr_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WB_ARB_IDLE;
         pend_addr <= '0;
         pend_data <= '0;
      end else if (state == WB_ARB_PEND) begin
         state <= WB_ARB_IDLE;
      end else if (dual_req) begin
         state     <= WB_ARB_PEND;
         pend_addr <= wb.base_addr_i;
         pend_data <= wb.val1_i;
      end
   end

   // PEND ignores the frozen MEM/WB inputs so the instruction cannot re-trigger
   always_comb begin
      port  = RF_WRITE_NONE;
      stall = 1'b0;
      if (!rst) begin
         if (state == WB_ARB_PEND) begin
            port = rf_write(pend_addr, pend_data);
         end else if (wb.wb_en_i) begin
            port  = rf_write(wb.dest_i, prim_data);
            stall = dual_req;
         end else if (wb.add_base_i) begin
            port = rf_write(wb.base_addr_i, wb.val1_i);
         end
      end
   end

   assign wb.rf_we_o   = port.we;
   assign wb.rf_addr_o = port.addr;
   assign wb.rf_data_o = port.data;
   assign wb.stall_o   = stall;

`ifdef WB_STALL_COUNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_port_arbiter : randomized instruction stream against a write-list model
// Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   typedef struct packed {
      logic        wb_en;
      logic        mem_r_en;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic [31:0] mem;
      logic        add_base;
      logic [4:0]  base;
      logic [31:0] val1;
   } instr_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        stall;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] stall_cnt;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [31:0] mdl_cnt = 32'd0;

   wb_port_arbiter_if bus();

   wb_port_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .wb          (bus)
`ifdef WB_STALL_COUNT_EN
      ,
      .stall_cnt_o (stall_cnt)
`endif
   );

`ifndef WB_STALL_COUNT_EN
   assign stall_cnt = 32'd0;
`endif

   always #5 clk = ~clk;

   function automatic instr_t mk(input logic wb_en, input logic mem_r_en, input logic [4:0] dest,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic add_base, input logic [4:0] base, input logic [31:0] val1);
      instr_t i;
      i.wb_en = wb_en; i.mem_r_en = mem_r_en; i.dest = dest; i.alu = alu; i.mem = mem;
      i.add_base = add_base; i.base = base; i.val1 = val1;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i.wb_en    = 1'($urandom_range(0, 1));
      i.mem_r_en = 1'($urandom_range(0, 1));
      i.dest     = 5'($urandom);
      i.alu      = $urandom;
      i.mem      = $urandom;
      i.add_base = 1'($urandom_range(0, 1));
      i.base     = ($urandom_range(0, 3) == 0) ? i.dest : 5'($urandom);
      i.val1     = $urandom;
      return i;
   endfunction

   task automatic drive(input logic r, input instr_t i);
      @(posedge clk);
      #1;
      rst                = r;
      bus.wb_en_i        = i.wb_en;
      bus.mem_r_en_i     = i.mem_r_en;
      bus.dest_i         = i.dest;
      bus.alu_res_i      = i.alu;
      bus.mem_read_val_i = i.mem;
      bus.add_base_i     = i.add_base;
      bus.base_addr_i    = i.base;
      bus.val1_i         = i.val1;
   endtask

   // One expected RF-port cycle; the counter model follows stalls and resets
   task automatic push(input logic r, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic st);
      exp_t e;
      e.we = we; e.addr = a; e.data = d; e.stall = st; e.cnt = mdl_cnt;
      exp_q.push_back(e);
      if (r) mdl_cnt = 32'd0;
      else if (st && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
   endtask

   task automatic reset_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         instr_t i;
         i = rand_instr();
         i.wb_en = 1'b1; i.add_base = 1'b1;
         drive(1'b1, i);
         push(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      end
   endtask

   // An instruction retires as an ordered list of register writes, one per cycle
   task automatic issue(input instr_t i, input bit rst_second, input bit garbage_second);
      logic [4:0]  wa[$];
      logic [31:0] wd[$];
      if (i.wb_en) begin
         wa.push_back(i.dest);
         wd.push_back(i.mem_r_en ? i.mem : i.alu);
      end
      if (i.add_base && !(i.wb_en && i.dest == i.base)) begin
         wa.push_back(i.base);
         wd.push_back(i.val1);
      end
      drive(1'b0, i);
      if (wa.size() == 0) push(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      else                push(1'b0, 1'b1, wa[0], wd[0], wa.size() > 1);
      if (wa.size() > 1) begin
         drive(rst_second, garbage_second ? rand_instr() : i);
         if (rst_second) push(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
         else            push(1'b0, 1'b1, wa[1], wd[1], 1'b0);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_we", 32'(bus.rf_we_o), 32'(e.we));
            check("rf_addr", 32'(bus.rf_addr_o), 32'(e.addr));
            check("rf_data", bus.rf_data_o, e.data);
            check("stall", 32'(bus.stall_o), 32'(e.stall));
`ifdef WB_STALL_COUNT_EN
            check("stall_cnt", stall_cnt, e.cnt);
`endif
         end
      end
   end

   initial begin
      reset_cycles(2);
      issue(mk(1'b1, 1'b0, 5'd5, 32'h1234, $urandom, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0);
      issue(mk(1'b1, 1'b1, 5'd3, $urandom, 32'hAAAA, 1'b1, 5'd7, 32'h104), 1'b0, 1'b0);
      issue(mk(1'b0, 1'b0, 5'd3, $urandom, 32'hAAAA, 1'b0, 5'd7, 32'h104), 1'b0, 1'b0);
      issue(mk(1'b1, 1'b1, 5'd4, $urandom, 32'h55, 1'b1, 5'd4, 32'h77), 1'b0, 1'b0);
      issue(mk(1'b0, 1'b0, 5'd1, 32'h99, 32'h98, 1'b0, 5'd2, 32'h97), 1'b0, 1'b0);
      issue(mk(1'b0, 1'b0, 5'd0, $urandom, $urandom, 1'b1, 5'd9, 32'd8), 1'b0, 1'b0);
      issue(mk(1'b1, 1'b0, 5'd10, 32'hC0DE, $urandom, 1'b1, 5'd11, 32'hBEEF), 1'b1, 1'b0);
      issue(mk(1'b1, 1'b0, 5'd12, 32'h12, $urandom, 1'b0, 5'd13, 32'h13), 1'b0, 1'b0);

      reset_cycles(1);
      for (int k = 0; k < 3; k++)
         issue(mk(1'b1, 1'b0, 5'(k + 1), $urandom, $urandom, 1'b1, 5'(k + 20), $urandom), 1'b0, 1'b0);
      issue(mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0);
      reset_cycles(1);
      issue(mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0);

      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 49) == 0) reset_cycles(1);
         issue(rand_instr(), $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      end

      repeat (3) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Sits between the MEM/WB pipeline register and the register file's single write port.
- Each retiring instruction may request two writes:
  - a primary write: ALU result or load data to `dest`;
  - a base-register update (`add_base`, post-increment/base-writeback addressing) of the `val1` value to the base register.
- The block serialises the two writes onto the one port. It asserts a stall to freeze upstream pipeline registers for the extra cycle.

Parameters:
- WORD_LEN, 32, datapath word width (shared define).
- REG_FILE_ADDR_LEN, 5, register-file address width (shared define).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- wb_en_i  input  1  primary writeback requested (MEM/WB WB_EN).
- mem_r_en_i  input  1  1 = primary data is memReadVal, 0 = ALURes.
- dest_i  input  REG_FILE_ADDR_LEN  primary destination register.
- alu_res_i  input  WORD_LEN  ALU result.
- mem_read_val_i  input  WORD_LEN  load data.
- add_base_i  input  1  base-register update requested.
- base_addr_i  input  REG_FILE_ADDR_LEN  base register index.
- val1_i  input  WORD_LEN  updated base value.
- rf_we_o  output  1  register-file write enable.
- rf_addr_o  output  REG_FILE_ADDR_LEN  register-file write address.
- rf_data_o  output  WORD_LEN  register-file write data.
- stall_o  output  1  freeze IF..MEM/WB registers this cycle.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- States: IDLE and PEND. Reset puts the FSM in IDLE and clears the pending registers (pend_addr=0, pend_data=0).
- Reset outputs: while rst is high, rf_we_o=0, rf_addr_o=0, rf_data_o=0, stall_o=0.
- Primary data: prim_data = mem_r_en_i ? mem_read_val_i : alu_res_i.
- IDLE decode, combinational outputs, zero latency to the RF port:
  - wb_en_i=0, add_base_i=0: rf_we_o=0, stall_o=0. Address and data are driven 0.
  - wb_en_i=1, add_base_i=0: write (dest_i, prim_data). stall_o=0.
  - wb_en_i=0, add_base_i=1: write (base_addr_i, val1_i). stall_o=0.
  - both=1, dest_i==base_addr_i: write (dest_i, prim_data) only. The base update is dropped because the load/primary result wins. stall_o=0.
  - both=1, dest_i!=base_addr_i: write (dest_i, prim_data) and capture pend_addr<=base_addr_i, pend_data<=val1_i. stall_o=1. Next state PEND.
- PEND:
  - Outputs: rf_we_o=1, rf_addr_o=pend_addr, rf_data_o=pend_data, stall_o=0. Next state IDLE.
  - All inputs are ignored in PEND. The frozen MEM/WB still presents the same instruction, and it must not re-trigger.
  - The new instruction presented in the following cycle is decoded normally in IDLE.
- Throughput: one write per cycle. A dual-write instruction costs exactly one stall cycle.
- Reset asserted in PEND: the pending write is discarded (rf_we_o=0 that cycle), next state IDLE, stall_o=0.
- No X propagation: when rf_we_o=0, address and data are driven 0.

Optional Feature:
- Macro WB_STALL_COUNT_EN.
- Defined:
  - adds output `stall_cnt_o [31:0]`, counting cycles with stall_o=1;
  - reset clears it to 0;
  - saturates at 32'hFFFFFFFF;
  - no other behavioural change.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- WORD_LEN and REG_FILE_ADDR_LEN come from the shared defines file.
- FSM state encoding (IDLE=1'b0, PEND=1'b1) lives in the shared defines/package as WB_ARB_IDLE and WB_ARB_PEND.
- No sub-module. The optional counter is inline logic inside the guard.

Test Plan:
- Reset: rst=1 for 2 cycles, random inputs → rf_we_o=0, stall_o=0, outputs 0. Held even when wb_en_i=add_base_i=1.
- Single ALU write: wb_en=1, mem_r_en=0, dest=5, alu_res=32'h1234 → same cycle rf_we=1, addr=5, data=32'h1234, stall=0.
- Dual write: wb_en=1, mem_r_en=1, dest=3, mem_read_val=32'hAAAA, add_base=1, base=7, val1=32'h104, held 2 cycles →
  - cycle0: (3, 32'hAAAA), stall=1;
  - cycle1: (7, 32'h104), stall=0;
  - cycle2 with wb_en=0: rf_we=0.
- Collision: both=1, dest=base=4, mem_read_val=32'h55 → single write (4, 32'h55), stall=0, FSM stays IDLE.
- Base-only write, then reset-in-PEND:
  - add_base=1, wb_en=0, base=9, val1=8 → write (9, 8), stall=0.
  - Then a dual request, with rst=1 in the PEND cycle → no write that cycle, next cycle IDLE.
- WB_STALL_COUNT_EN: three back-to-back dual-write instructions → stall_cnt_o=3. Rst → 0.
